pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in bits.
REQ-002 SHALL have parameter FLUSH_CYC, default 2, number of squash cycles after a taken branch (range 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  freeze request from the pipeline hazard logic.
REQ-006 SHALL have port br_valid  input  1  decoded jump/branch in the execute slot this cycle.
REQ-007 SHALL have port br_cond  input  1  1 = conditional on FL, 0 = unconditional.
REQ-008 SHALL have port br_target  input  PC_W  jump destination from IR.
REQ-009 SHALL have port FL  input  1  selected condition flag from the flag register, registered upstream, used combinationally.
REQ-010 SHALL have port halt_req  input  1  HLT decoded.
REQ-011 SHALL have port pc  output  PC_W  fetch address.
REQ-012 SHALL have port pc_valid  output  1  fetch enable.
REQ-013 SHALL have port flush  output  1  squash IF/ID stages.
REQ-014 SHALL have port taken  output  1  one-cycle pulse per taken branch.
REQ-015 SHALL have port halted  output  1  core halted.

Function
REQ-016 SHALL implement states RUN, FLUSH and HALT; all outputs SHALL be registered.
REQ-017 In RUN, with stall=0 and br_valid=0, pc SHALL increment by 1 per cycle and wrap from 2^PC_W-1 to 0.
REQ-018 In RUN, with br_valid=1, taken SHALL be computed as (~br_cond | FL), with FL sampled in the same cycle.
REQ-019 On a taken branch: next pc = br_target; taken = 1 for one cycle; flush = 1; flush counter loaded with FLUSH_CYC-1; state -> FLUSH.
REQ-020 On a not-taken branch: pc SHALL increment as in REQ-017; no flush; no taken pulse.
REQ-021 In FLUSH: pc SHALL increment; flush SHALL stay 1; br_valid and halt_req SHALL be ignored; the counter SHALL decrement; at count 0 the state SHALL return to RUN and flush SHALL drop on that edge (flush asserted exactly FLUSH_CYC cycles).
REQ-022 stall=1 SHALL freeze pc, state and counter, and SHALL suppress the branch/halt decision that cycle; flush and taken SHALL hold their values except that taken SHALL be forced to 0.
REQ-023 In RUN, halt_req=1 with stall=0 SHALL move the state to HALT with pc_valid=0, halted=1 and pc frozen; halt_req SHALL take priority over a simultaneous br_valid.
REQ-024 HALT SHALL be exited only by rst.

Reset
REQ-025 On rst: pc=0, pc_valid=1, flush=0, taken=0, halted=0, state=RUN, counter=0; assertion mid-FLUSH or in HALT SHALL abort immediately.
REQ-026 The first fetch after rst deassertion SHALL be address 0.

Configuration
REQ-027 Macro RAS_EN SHALL add inputs call and ret (1 bit each), and a 4-entry return-address stack.
REQ-028 With RAS_EN defined: call SHALL behave as an unconditional taken branch that also pushes pc+1.
REQ-029 With RAS_EN defined: ret SHALL be taken with target = the popped entry, ignoring br_target.
REQ-030 With RAS_EN defined: a push when full SHALL overwrite the oldest entry.
REQ-031 With RAS_EN defined: a pop when empty SHALL return 0 and set a sticky output ras_err (1 bit, cleared by rst).
REQ-032 Without RAS_EN: the call, ret and ras_err ports and the stack logic SHALL be absent.

Structure
REQ-033 Shared package pipe_pkg SHALL hold PC_W and FLUSH_CYC defaults, the state encoding (RUN/FLUSH/HALT) and the RAS depth constant.
REQ-034 The return-address stack SHALL be sub-module ras_stack, instantiated only under RAS_EN.

Verification
REQ-035 Reset, then 5 free-running cycles -> pc = 0,1,2,3,4; flush = 0; pc_valid = 1.
REQ-036 br_valid=1, br_cond=1, FL=1, br_target=8'h40 at pc=8'h05 -> next pc = 8'h40; taken pulses 1 cycle; flush high exactly 2 cycles; a br_valid during FLUSH is ignored.
REQ-037 Same stimulus with FL=0 -> pc = 8'h06; taken = 0; flush = 0.
REQ-038 pc = 8'hFF, no branch -> next pc = 8'h00; stall held 3 cycles mid-FLUSH -> pc and flush frozen, then 1 remaining flush cycle.
REQ-039 halt_req and br_valid in the same cycle -> halted = 1, pc_valid = 0, pc unchanged; rst asserted asynchronously mid-FLUSH -> outputs return to reset values before the next edge.
REQ-040 RAS_EN: call at pc=8'h10 to 8'h30, then ret -> pc = 8'h11; 5 calls then 5 rets -> 5th ret returns 0 and ras_err = 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the PC branch unit state encoding.
// The optional RAS_EN build adds a return-address stack sized by RasDepth.
package pipe_pkg;

  localparam int unsigned PcWidthDefault  = 8;
  localparam int unsigned FlushCycDefault = 2;
  localparam int unsigned RasDepth        = 4;
  localparam int unsigned CntW            = 3;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StFlush = 2'd1,
    StHalt  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: a circular buffer, so a push when full overwrites the oldest entry.
// A pop when empty returns 0 and sets the sticky err flag.
module ras_stack
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W = PcWidthDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic            err
);

  localparam int unsigned PtrW = $clog2(RasDepth);

  logic [PC_W-1:0] mem [RasDepth];
  logic [PtrW-1:0] top;     // next slot to write
  logic [PtrW-1:0] top_m1;
  logic [PtrW:0]   count;

  assign top_m1   = top - PtrW'(1);
  assign pop_data = (count == '0) ? '0 : mem[top_m1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RasDepth; i++) begin
        mem[i] <= '0;
      end
      top   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (push) begin
      mem[top] <= push_data;
      top      <= top + PtrW'(1);
      if (count != (PtrW + 1)'(RasDepth)) begin
        count <= count + (PtrW + 1)'(1);
      end
    end else if (pop) begin
      if (count == '0) begin
        err <= 1'b1;
      end else begin
        top   <= top_m1;
        count <= count - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution with post-branch squash and halt.
// Define RAS_EN to add call/ret inputs, a return-address stack and the ras_err flag.
module pc_branch_unit
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W      = PcWidthDefault,
  parameter int unsigned FLUSH_CYC = FlushCycDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            FL,
  input  logic            halt_req,
`ifdef RAS_EN
  input  logic            call,
  input  logic            ret,
  output logic            ras_err,
`endif
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            taken,
  output logic            halted
);

  pipe_state_e     state;
  logic [CntW-1:0] cnt;
  logic [PC_W-1:0] pc_inc;
  logic            decide;
  logic            br_take;
  logic [PC_W-1:0] br_dest;

  assign pc_inc = pc + PC_W'(1);
  // Branch decisions are only made in RUN, unstalled, and lose to a halt request.
  assign decide = (state == StRun) && !stall && !halt_req;

`ifdef RAS_EN
  logic            do_call;
  logic            do_ret;
  logic [PC_W-1:0] ras_top;

  assign do_call = decide && call;
  assign do_ret  = decide && ret && !call;
  assign br_take = do_call || do_ret || (decide && br_valid && (!br_cond || FL));
  assign br_dest = do_ret ? ras_top : br_target;

  ras_stack #(
    .PC_W(PC_W)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (do_call),
    .pop      (do_ret),
    .push_data(pc_inc),
    .pop_data (ras_top),
    .err      (ras_err)
  );
`else
  assign br_take = decide && br_valid && (!br_cond || FL);
  assign br_dest = br_target;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StRun;
      cnt      <= '0;
      pc       <= '0;
      pc_valid <= 1'b1;
      flush    <= 1'b0;
      taken    <= 1'b0;
      halted   <= 1'b0;
    end else if (stall) begin
      taken <= 1'b0;
    end else begin
      unique case (state)
        StRun: begin
          taken <= 1'b0;
          if (halt_req) begin
            state    <= StHalt;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end else if (br_take) begin
            state <= StFlush;
            pc    <= br_dest;
            taken <= 1'b1;
            flush <= 1'b1;
            cnt   <= CntW'(FLUSH_CYC - 1);
          end else begin
            pc <= pc_inc;
          end
        end
        StFlush: begin
          pc    <= pc_inc;
          taken <= 1'b0;
          if (cnt == '0) begin
            state <= StRun;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StHalt: begin
          taken <= 1'b0;
        end
        default: begin
          state <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; the RAS section runs only when RAS_EN is defined.
module tb_pc_branch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       br_valid = 1'b0;
  logic       br_cond = 1'b0;
  logic [7:0] br_target = 8'h00;
  logic       FL = 1'b0;
  logic       halt_req = 1'b0;
  logic [7:0] pc;
  logic       pc_valid;
  logic       flush;
  logic       taken;
  logic       halted;
`ifdef RAS_EN
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic       ras_err;
`endif

  int errors = 0;
  int checks = 0;

  pc_branch_unit #(
    .PC_W     (8),
    .FLUSH_CYC(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .br_valid (br_valid),
    .br_cond  (br_cond),
    .br_target(br_target),
    .FL       (FL),
    .halt_req (halt_req),
`ifdef RAS_EN
    .call     (call),
    .ret      (ret),
    .ras_err  (ras_err),
`endif
    .pc       (pc),
    .pc_valid (pc_valid),
    .flush    (flush),
    .taken    (taken),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

`ifdef RAS_EN
  logic [7:0] call_tgt [5];
  logic [7:0] ret_exp  [5];
`endif

  initial begin
    // Reset values while rst is held.
    step();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_pc_valid", pc_valid, 1);
    chk("rst_flush", flush, 0);
    chk("rst_taken", taken, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;

    // Free-running fetch from address 0.
    for (int i = 0; i < 5; i++) begin
      chk("free_pc", pc, i);
      chk("free_flush", flush, 0);
      chk("free_pc_valid", pc_valid, 1);
      step();
    end
    chk("pre_br_pc", pc, 8'h05);

    // Taken conditional branch; br_valid during FLUSH must be ignored.
    br_valid = 1'b1; br_cond = 1'b1; FL = 1'b1; br_target = 8'h40;
    step();
    chk("br_pc", pc, 8'h40);
    chk("br_taken", taken, 1);
    chk("br_flush1", flush, 1);
    br_cond = 1'b0; br_target = 8'h80;
    step();
    chk("fl_pc", pc, 8'h41);
    chk("fl_taken", taken, 0);
    chk("br_flush2", flush, 1);
    step();
    chk("fl_end_pc", pc, 8'h42);
    chk("fl_end_flush", flush, 0);
    br_valid = 1'b0;
    step();
    chk("run_after_fl_pc", pc, 8'h43);

    // Not-taken conditional at pc=05.
    do_reset();
    repeat (5) step();
    chk("nt_pre_pc", pc, 8'h05);
    br_valid = 1'b1; br_cond = 1'b1; FL = 1'b0; br_target = 8'h40;
    step();
    chk("nt_pc", pc, 8'h06);
    chk("nt_taken", taken, 0);
    chk("nt_flush", flush, 0);

    // Unconditional branch ignores FL=0; then wrap from FF to 00 in RUN.
    br_cond = 1'b0; br_target = 8'hFC;
    step();
    chk("uc_pc", pc, 8'hFC);
    chk("uc_taken", taken, 1);
    br_valid = 1'b0;
    step();
    step();
    chk("uc_fl_end_pc", pc, 8'hFE);
    chk("uc_fl_end_flush", flush, 0);
    step();
    chk("wrap_pre_pc", pc, 8'hFF);
    step();
    chk("wrap_pc", pc, 8'h00);

    // Stall for 3 cycles mid-FLUSH freezes pc and flush.
    br_valid = 1'b1; br_target = 8'h20;
    step();
    chk("st_br_pc", pc, 8'h20);
    chk("st_br_flush", flush, 1);
    br_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pc", pc, 8'h20);
      chk("st_flush", flush, 1);
      chk("st_taken", taken, 0);
    end
    stall = 1'b0;
    step();
    chk("st_rem_pc", pc, 8'h21);
    chk("st_rem_flush", flush, 1);
    step();
    chk("st_done_pc", pc, 8'h22);
    chk("st_done_flush", flush, 0);

    // Stall in RUN suppresses a taken branch.
    stall = 1'b1; br_valid = 1'b1; br_target = 8'h70;
    step();
    chk("sb_pc", pc, 8'h22);
    chk("sb_taken", taken, 0);
    chk("sb_flush", flush, 0);
    stall = 1'b0; br_valid = 1'b0;
    step();
    chk("sb_after_pc", pc, 8'h23);

    // Halt wins over a simultaneous branch and persists.
    halt_req = 1'b1; br_valid = 1'b1;
    step();
    chk("h_halted", halted, 1);
    chk("h_pc_valid", pc_valid, 0);
    chk("h_pc", pc, 8'h23);
    chk("h_taken", taken, 0);
    halt_req = 1'b0;
    step();
    chk("h_hold_pc", pc, 8'h23);
    chk("h_hold_halted", halted, 1);
    br_valid = 1'b0;

    // Asynchronous reset out of HALT, observed before the next edge.
    #3;
    rst = 1'b1;
    #1;
    chk("ar_h_halted", halted, 0);
    chk("ar_h_pc_valid", pc_valid, 1);
    chk("ar_h_pc", pc, 0);
    step();
    rst = 1'b0;
    chk("ar_first_pc", pc, 0);

    // Asynchronous reset mid-FLUSH.
    repeat (2) step();
    br_valid = 1'b1; br_cond = 1'b0; br_target = 8'h50;
    step();
    chk("ar_f_pc_pre", pc, 8'h50);
    chk("ar_f_flush_pre", flush, 1);
    br_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("ar_f_pc", pc, 0);
    chk("ar_f_flush", flush, 0);
    chk("ar_f_taken", taken, 0);
    step();
    rst = 1'b0;
    step();
    chk("ar_f_after_pc", pc, 8'h01);
    chk("ar_f_after_flush", flush, 0);

`ifdef RAS_EN
    call_tgt[0] = 8'h80; call_tgt[1] = 8'h90; call_tgt[2] = 8'hA0;
    call_tgt[3] = 8'hB0; call_tgt[4] = 8'hC0;
    ret_exp[0] = 8'hB3; ret_exp[1] = 8'hA3; ret_exp[2] = 8'h93;
    ret_exp[3] = 8'h83; ret_exp[4] = 8'h00;
    do_reset();
    repeat (16) step();
    chk("ras_pre_pc", pc, 8'h10);
    call = 1'b1; br_target = 8'h30;
    step();
    chk("ras_call_pc", pc, 8'h30);
    chk("ras_call_taken", taken, 1);
    call = 1'b0;
    repeat (2) step();
    chk("ras_run_pc", pc, 8'h32);
    ret = 1'b1;
    step();
    chk("ras_ret_pc", pc, 8'h11);
    ret = 1'b0;
    repeat (2) step();
    chk("ras_err_clear", ras_err, 0);
    // Five pushes into a 4-deep stack drop the oldest (0x14).
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; br_target = call_tgt[i];
      step();
      call = 1'b0;
      repeat (2) step();
    end
    for (int i = 0; i < 5; i++) begin
      ret = 1'b1;
      step();
      chk("ras_pop_pc", pc, ret_exp[i]);
      ret = 1'b0;
      repeat (2) step();
    end
    chk("ras_err_set", ras_err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
